// File: rtl/obstacle_scheduler.sv
// Obstacle scheduler: paces random obstacle descriptors into a small FIFO for the track renderer.
// Latency: head appears 1 clk after a push into an empty FIFO; next head 1 clk after an accept.
// Backpressure: o_obs_valid/i_obs_ready; a full FIFO holds the pending spawn with o_stall=1.
//
// Ports:
//   i_clk, i_reset (async, active-low)
//   i_random_number : 20-bit LFSR word
//   i_frame_tick : one-clk pulse per video frame
//   i_game_active : 0 freezes scheduling
//   o_obs_valid/i_obs_ready/o_obs_lane/o_obs_type/o_obs_gap : registered FIFO head + handshake
//   o_level : difficulty 0..3
//   o_stall : spawn pending but FIFO full
// Optional macro OBS_STATS_EN adds o_spawn_count (wrapping) and o_stall_cycles (saturating).
module obstacle_scheduler #(
    parameter int DEPTH        = 4,
    parameter int MIN_GAP      = 8,
    parameter int LEVEL_SPAWNS = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [19:0] i_random_number,
    input  logic        i_frame_tick,
    input  logic        i_game_active,
    output logic        o_obs_valid,
    input  logic        i_obs_ready,
    output logic [1:0]  o_obs_lane,
    output logic [1:0]  o_obs_type,
    output logic [7:0]  o_obs_gap,
    output logic [1:0]  o_level,
    output logic        o_stall
`ifdef OBS_STATS_EN
    ,
    output logic [15:0] o_spawn_count,
    output logic [15:0] o_stall_cycles
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(LEVEL_SPAWNS + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DRAW = 2'd2;
    localparam logic [1:0] S_PUSH = 2'd3;

    typedef struct packed {
        logic [1:0] lane;
        logic [1:0] typ;
        logic [7:0] gap;
    } obs_t;

    logic [1:0]  r_state;
    logic [7:0]  r_countdown;
    logic [19:0] r_last_rnd;
    logic [1:0]  r_prev1;
    logic [1:0]  r_prev2;
    obs_t        r_pend;
    logic [1:0]  r_level;
    logic [LW-1:0] r_lvl_cnt;
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    obs_t        r_mem [DEPTH];
    obs_t        r_head;
    logic        r_head_vld;

    logic [AW:0] w_count;
    logic [AW:0] w_rd_next;
    logic        w_full;
    logic        w_pop;
    logic        w_push;
    logic        w_head_vld_nxt;
    logic [1:0]  w_lane_raw;
    logic [1:0]  w_lane_base;
    logic [1:0]  w_lane;
    logic [7:0]  w_gap;

    assign w_count   = r_wr_ptr - r_rd_ptr;
    assign w_rd_next = r_rd_ptr + 1'b1;
    assign w_full    = (w_count == (AW+1)'(DEPTH));
    assign w_pop     = r_head_vld & i_obs_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign w_push    = (r_state == S_PUSH) & i_game_active & (~w_full | w_pop);
    assign o_stall   = (r_state == S_PUSH) & w_full & ~w_pop;

    // Head register tracks the entry count seen before this edge, which gives the
    // one-clk delay after a push and drops valid right after the last entry is taken.
    assign w_head_vld_nxt = (w_count != '0) && !(w_pop && (w_count == (AW+1)'(1)));

    // Lane selection: fold raw 3 onto left/centre, then break any run of three.
    assign w_lane_raw  = i_random_number[1:0];
    assign w_lane_base = (w_lane_raw == 2'd3) ? {1'b0, i_random_number[2]} : w_lane_raw;
    assign w_lane      = (w_lane_base == r_prev1 && w_lane_base == r_prev2)
                         ? ((w_lane_base == 2'd2) ? 2'd0 : w_lane_base + 2'd1)
                         : w_lane_base;
    assign w_gap       = 8'(MIN_GAP) + (8'(i_random_number[9:4]) >> r_level);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state     <= S_IDLE;
            r_countdown <= '0;
            r_last_rnd  <= '0;
            r_prev1     <= 2'd3;
            r_prev2     <= 2'd3;
            r_pend      <= '0;
            r_level     <= '0;
            r_lvl_cnt   <= '0;
            r_wr_ptr    <= '0;
        end else if (i_game_active) begin
            case (r_state)
                S_IDLE: r_state <= S_WAIT;
                S_WAIT: begin
                    if (r_countdown == '0) begin
                        r_state <= S_DRAW;
                    end else if (i_frame_tick) begin
                        r_countdown <= r_countdown - 8'd1;
                    end
                end
                S_DRAW: begin
                    // Only a word different from the last one drawn counts as fresh.
                    if (i_random_number != r_last_rnd) begin
                        r_last_rnd <= i_random_number;
                        r_pend     <= '{lane: w_lane, typ: i_random_number[3:2], gap: w_gap};
                        r_state    <= S_PUSH;
                    end
                end
                default: begin
                    if (w_push) begin
                        r_wr_ptr    <= r_wr_ptr + 1'b1;
                        r_countdown <= r_pend.gap;
                        r_prev2     <= r_prev1;
                        r_prev1     <= r_pend.lane;
                        r_state     <= S_WAIT;
                        if (r_level != 2'd3) begin
                            if (r_lvl_cnt == LW'(LEVEL_SPAWNS - 1)) begin
                                r_lvl_cnt <= '0;
                                r_level   <= r_level + 2'd1;
                            end else begin
                                r_lvl_cnt <= r_lvl_cnt + 1'b1;
                            end
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= r_pend;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_rd_ptr   <= '0;
            r_head     <= '0;
            r_head_vld <= 1'b0;
        end else begin
            if (w_pop) begin
                r_rd_ptr <= w_rd_next;
            end
            r_head_vld <= w_head_vld_nxt;
            if (!w_head_vld_nxt) begin
                r_head <= '0;
            end else if (w_pop) begin
                r_head <= r_mem[w_rd_next[AW-1:0]];
            end else begin
                r_head <= r_mem[r_rd_ptr[AW-1:0]];
            end
        end
    end

    assign o_obs_valid = r_head_vld;
    assign o_obs_lane  = r_head.lane;
    assign o_obs_type  = r_head.typ;
    assign o_obs_gap   = r_head.gap;
    assign o_level     = r_level;

`ifdef OBS_STATS_EN
    logic [15:0] r_spawn_count;
    logic [15:0] r_stall_cycles;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_spawn_count  <= '0;
            r_stall_cycles <= '0;
        end else begin
            if (w_push) begin
                r_spawn_count <= r_spawn_count + 16'd1;
            end
            if (o_stall && r_stall_cycles != 16'hFFFF) begin
                r_stall_cycles <= r_stall_cycles + 16'd1;
            end
        end
    end

    assign o_spawn_count  = r_spawn_count;
    assign o_stall_cycles = r_stall_cycles;
`endif

endmodule

// File: doc/obstacle_scheduler.md
Name: obstacle_scheduler

Overview:
- Consumes the 20-bit LFSR word from the random generator and turns it into a paced stream of obstacle descriptors (lane, type, gap) for the track renderer.
- Runs on frame ticks: counts down a random gap, then draws a fresh random word and pushes one descriptor into a small FIFO.
- The renderer drains the FIFO through a valid/ready handshake.
- Difficulty level rises with spawn count and shortens gaps.

Parameters:
- DEPTH, 4, FIFO entries (power of 2, 2..16)
- MIN_GAP, 8, minimum frames between spawns
- LEVEL_SPAWNS, 16, spawns per level increment

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- random_number  in  20  LFSR word, changes at most once per 21 clk
- frame_tick  in  1  one-clk pulse per video frame
- game_active  in  1  1 = running; 0 = pause scheduling
- obs_valid  out  1  FIFO head valid
- obs_ready  in  1  renderer accepts head when obs_valid & obs_ready
- obs_lane  out  2  0/1/2 = left/centre/right
- obs_type  out  2  rnd[3:2] of sampled word
- obs_gap  out  8  frames until the next spawn (from this descriptor)
- level  out  2  difficulty 0..3, saturating
- stall  out  1  spawn pending but FIFO full

Behaviour:
- Reset (async, reset==0) sets all outputs and state to 0: obs_valid=0, lane/type/gap=0, level=0, stall=0, FIFO empty, countdown=0, state IDLE, last_rnd=0, prev lanes=3 (invalid).
- States:
  - IDLE: goes to WAIT when game_active=1.
  - WAIT: countdown decrements on each frame_tick while game_active. Goes to DRAW when countdown==0, either at entry or after a tick.
  - DRAW: waits until random_number != last_rnd (fresh word), then latches it into last_rnd and computes the descriptor in that same cycle. Goes to PUSH.
  - PUSH: if FIFO not full, writes the entry, reloads countdown=gap, and goes to WAIT. If full, holds with stall=1 and loses no descriptor.
- game_active=0 in any state freezes countdown and state. The FIFO keeps draining.
- Lane: raw = rnd[1:0]. raw==3 maps to {1'b0,rnd[2]}. If the result equals both of the previous two pushed lanes, lane = (lane+1) mod 3.
- Gap: gap = MIN_GAP + (rnd[9:4] >> level). This is 8-bit and cannot overflow with defaults. The max is 8+63=71.
- Level: increments after every LEVEL_SPAWNS accepted pushes and saturates at 3. It is sampled at DRAW.
- FIFO:
  - Pointers use one wrap bit.
  - Full when count==DEPTH; empty when count==0.
  - A simultaneous push and pop when full is allowed. The pop frees the slot in the same cycle, so the push proceeds and stall=0.
  - A simultaneous push and pop when empty is not permitted, because obs_valid=0.
- Outputs obs_* are registered views of the FIFO head. obs_valid rises 1 clk after the push into an empty FIFO.
- Pop latency: the next head appears on the clk after the accept.
- frame_tick while in DRAW or PUSH is ignored; there is no countdown underflow.
- Reset mid-operation discards FIFO contents and level immediately.

Optional Feature:
- Macro OBS_STATS_EN.
- When defined, adds output spawn_count[15:0] (accepted pushes, wrapping at 16'hFFFF→0) and stall_cycles[15:0] (clk cycles with stall=1, saturating at 16'hFFFF). Both are cleared by reset.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Reset then game_active=1, random_number=20'h00015, obs_ready=1 → one push: lane=1, type=1, gap=9. obs_valid pulses 1 clk after the push.
- random_number held constant across two spawn cycles → second DRAW waits (no push) until the word changes to 20'h003F2. Then: lane=2, type=0, gap=8+63=71.
- Lanes drawn 0,0,0 (words 20'h00010, 20'h00020, 20'h00030) → third obs_lane=1.
- obs_ready=0 and DEPTH=4 → after 4 pushes stall=1 and state holds. Raising obs_ready for 1 clk → stall=0 and the fifth entry is written that cycle.
- 16 accepted spawns → level=1; random_number[9:4]=6'h3F → gap=8+31=39. After 48 spawns, level stays 3.
- Assert reset low mid-WAIT with 2 entries queued → obs_valid=0 and level=0 immediately (async). With OBS_STATS_EN, spawn_count=0.
